// File: rtl/seg7_scan_ctrl_if.sv
// Write-side handshake for the seven-segment scan controller.
// The CPU I/O path (master) offers a 32-bit value with wr_en; the
// controller (slave) takes it only while wr_ready is high.
interface seg7_scan_ctrl_if;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        wr_ready;

    modport master (
        output wr_en,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_en,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Eight-digit seven-segment scan controller.
// A written 32-bit value is held in a pending buffer and copied to the
// displayed value only at a frame boundary (tick while on digit 7), so a
// frame never shows a mix of old and new digits. Digits are scanned one
// per CLK_DIV cycles onto active-low segment/select pins.
// Optional feature: define SEG7_LZB_EN to blank leading zero digits
// (digit 0 is never blanked).
module seg7_scan_ctrl #(
    parameter int CLK_DIV = 50000
) (
    input  logic                    clk_in,
    input  logic                    reset,
    seg7_scan_ctrl_if.slave         wr,
    output logic                    frame_done,
    output logic [7:0]              o_seg,
    output logic [7:0]              o_sel
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]       dig_q, dig_d;
    logic [31:0]      disp_q, disp_d;
    logic [31:0]      pend_q, pend_d;
    logic             pend_v_q, pend_v_d;
    logic             wr_ready_q;
    logic             frame_done_q;
    logic [7:0]       o_seg_q, o_seg_d;
    logic [7:0]       o_sel_q, o_sel_d;

    logic             tick;
    logic             boundary;
    logic             wr_accept;
    logic [3:0]       nibble;
    logic [7:0]       hex_seg;
    logic [7:0]       digit_nz;

    assign tick      = (div_cnt_q == DIV_LAST);
    assign wr_accept = wr.wr_en && wr_ready_q;

    // digit_nz[i]: some nibble at position i or above is non-zero, i.e.
    // digit i is not a leading zero.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_nz
            assign digit_nz[gi] = |disp_q[31:4*gi];
        end
    endgenerate

    // Prescaler: free-running 0..CLK_DIV-1 counter.
    always_comb begin
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    end

    // Digit ring state register (S0..S7).
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            dig_q <= 3'd0;
        end else begin
            dig_q <= dig_d;
        end
    end

    // Digit ring next state: advance on tick, 7 wraps to 0 naturally.
    always_comb begin
        dig_d = tick ? dig_q + 3'd1 : dig_q;
    end

    // Digit ring outputs: frame boundary and the next select/segment pattern.
    always_comb begin
        boundary = tick && (dig_q == 3'd7);
        o_sel_d  = ~(8'b1 << dig_q);
        nibble   = disp_q[4*dig_q +: 4];
        case (nibble)
            4'h0:    hex_seg = 8'hC0;
            4'h1:    hex_seg = 8'hF9;
            4'h2:    hex_seg = 8'hA4;
            4'h3:    hex_seg = 8'hB0;
            4'h4:    hex_seg = 8'h99;
            4'h5:    hex_seg = 8'h92;
            4'h6:    hex_seg = 8'h82;
            4'h7:    hex_seg = 8'hF8;
            4'h8:    hex_seg = 8'h80;
            4'h9:    hex_seg = 8'h90;
            4'hA:    hex_seg = 8'h88;
            4'hB:    hex_seg = 8'h83;
            4'hC:    hex_seg = 8'hC6;
            4'hD:    hex_seg = 8'hA1;
            4'hE:    hex_seg = 8'h86;
            default: hex_seg = 8'h8E;
        endcase
`ifdef SEG7_LZB_EN
        o_seg_d = ((dig_q != 3'd0) && !digit_nz[dig_q]) ? 8'hFF : hex_seg;
`else
        o_seg_d = hex_seg;
`endif
    end

    // Buffers: a write fills pend; the boundary sees the pre-write pend_v,
    // so a write landing on the boundary cycle waits for the next frame.
    always_comb begin
        pend_d   = wr_accept ? wr.wr_data : pend_q;
        pend_v_d = (pend_v_q && !boundary) || wr_accept;
        disp_d   = (boundary && pend_v_q) ? pend_q : disp_q;
    end

    // All registered state, cleared asynchronously; outputs idle all-off.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            div_cnt_q    <= '0;
            disp_q       <= 32'd0;
            pend_q       <= 32'd0;
            pend_v_q     <= 1'b0;
            wr_ready_q   <= 1'b1;
            frame_done_q <= 1'b0;
            o_seg_q      <= 8'hFF;
            o_sel_q      <= 8'hFF;
        end else begin
            div_cnt_q    <= div_cnt_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_v_q     <= pend_v_d;
            wr_ready_q   <= ~pend_v_d;
            frame_done_q <= boundary;
            o_seg_q      <= o_seg_d;
            o_sel_q      <= o_sel_d;
        end
    end

    assign wr.wr_ready = wr_ready_q;
    assign frame_done  = frame_done_q;
    assign o_seg       = o_seg_q;
    assign o_sel       = o_sel_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized bench for seg7_scan_ctrl with a cycle-count based reference
// model: scan position and frame boundaries are derived arithmetically from
// the number of clock edges since reset release.
module tb_seg7_scan_ctrl;

    localparam int D     = 4;
    localparam int FRAME = 8 * D;

    logic       clk_in = 1'b0;
    logic       reset  = 1'b1;
    logic       frame_done;
    logic [7:0] o_seg;
    logic [7:0] o_sel;

    seg7_scan_ctrl_if wr_if ();

    seg7_scan_ctrl #(.CLK_DIV(D)) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .wr         (wr_if.slave),
        .frame_done (frame_done),
        .o_seg      (o_seg),
        .o_sel      (o_sel)
    );

    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          m_n;       // edges since reset release
    logic [31:0] m_disp;
    logic [31:0] m_pend;
    bit          m_pend_v;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0; 4'h1: return 8'hF9; 4'h2: return 8'hA4; 4'h3: return 8'hB0;
            4'h4: return 8'h99; 4'h5: return 8'h92; 4'h6: return 8'h82; 4'h7: return 8'hF8;
            4'h8: return 8'h80; 4'h9: return 8'h90; 4'hA: return 8'h88; 4'hB: return 8'h83;
            4'hC: return 8'hC6; 4'hD: return 8'hA1; 4'hE: return 8'h86; default: return 8'h8E;
        endcase
    endfunction

    function automatic logic [7:0] seg_of(input logic [31:0] v, input int d);
        logic [31:0] upper;
        upper = v >> (4 * d);
`ifdef SEG7_LZB_EN
        if (d > 0 && upper == 32'd0) return 8'hFF;
`endif
        return hex7(upper[3:0]);
    endfunction

    function automatic int cur_dig();
        return (m_n / D) % 8;
    endfunction

    task automatic model_reset();
        m_n = 0; m_disp = 0; m_pend = 0; m_pend_v = 0;
    endtask

    // One clock: predict from current model state and inputs, then check.
    task automatic step();
        bit acc, bnd;
        int d;
        logic [7:0] e_sel, e_seg;
        acc   = wr_if.wr_en && !m_pend_v;
        bnd   = (m_n % FRAME) == FRAME - 1;
        d     = cur_dig();
        e_sel = ~(8'b1 << d);
        e_seg = seg_of(m_disp, d);
        if (acc)
            $display("write accepted data=%h cycle=%0d digit=%0d boundary=%0d", wr_if.wr_data, m_n, d, bnd);
        if (bnd) begin
            if (m_pend_v) m_disp = m_pend;
            m_pend_v = 0;
        end
        if (acc) begin
            m_pend   = wr_if.wr_data;
            m_pend_v = 1;
        end
        m_n++;
        @(posedge clk_in);
        #1;
        check("o_sel", {24'd0, o_sel}, {24'd0, e_sel});
        check("o_seg", {24'd0, o_seg}, {24'd0, e_seg});
        check("frame_done", {31'd0, frame_done}, {31'd0, bnd});
        check("wr_ready", {31'd0, wr_if.wr_ready}, {31'd0, !m_pend_v});
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_sel"}, {24'd0, o_sel}, 32'hFF);
        check({tag, "_seg"}, {24'd0, o_seg}, 32'hFF);
        check({tag, "_rdy"}, {31'd0, wr_if.wr_ready}, 32'd1);
        check({tag, "_fd"}, {31'd0, frame_done}, 32'd0);
    endtask

    // Offer one value for a single cycle.
    task automatic write_once(input logic [31:0] v);
        wr_if.wr_en = 1'b1; wr_if.wr_data = v;
        step();
        wr_if.wr_en = 1'b0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 2 * FRAME && m_pend_v; k++) step();
    endtask

    initial begin
        wr_if.wr_en   = 1'b0;
        wr_if.wr_data = 32'd0;
        model_reset();

        // Reset held: all-off outputs, ready high.
        repeat (3) @(posedge clk_in);
        #1;
        check_idle("reset");
        #3 reset = 1'b0;

        // Free-running scan of zeros for two frames (FE/C0 first).
        run(2 * FRAME + 3);

        // Mid-frame write; display stays 0 until the boundary.
        write_once(32'h01234567);
        run(2 * FRAME);

        // Two writes with wr_en held: second waits for the boundary.
        wait_ready();
        wr_if.wr_en = 1'b1; wr_if.wr_data = 32'hAAAAAAAA;
        step();
        wr_if.wr_data = 32'h55555555;
        for (int k = 0; k < 2 * FRAME && m_pend_v; k++) step();
        step();
        wr_if.wr_en = 1'b0;
        run(2 * FRAME);

        // Write exactly on the boundary cycle.
        wait_ready();
        for (int k = 0; k < FRAME && (m_n % FRAME) != FRAME - 1; k++) step();
        write_once(32'h89ABCDEF);
        run(2 * FRAME + 2);

        // Leading-zero pattern.
        write_once(32'h000000A0);
        run(2 * FRAME);

        // Async reset while a write is pending and digit 5 is scanned.
        wait_ready();
        for (int k = 0; k < FRAME && (m_n % FRAME) != 0; k++) step();
        write_once(32'hDEADBEEF);
        for (int k = 0; k < FRAME && cur_dig() != 5; k++) step();
        #2 reset = 1'b1;
        #1;
        check_idle("async_reset");
        #2 reset = 1'b0;
        model_reset();
        run(FRAME + 4);

        // Randomized traffic.
        for (int k = 0; k < 800; k++) begin
            wr_if.wr_en   = ($urandom_range(0, 7) == 0);
            wr_if.wr_data = $urandom;
            if ($urandom_range(0, 3) == 0) wr_if.wr_data = wr_if.wr_data >> (4 * $urandom_range(1, 7));
            step();
        end
        wr_if.wr_en = 1'b0;
        run(FRAME);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
